// File: rtl/fft_pkg.sv
// Shared types for the in-place radix-2 DIT FFT sequencer: packed complex word,
// FSM state encoding and the per-stage halving used when FFT_SCALE_EN is defined.
package fft_pkg;

  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_FINISH
  } fft_state_t;

  // Arithmetic shift right by one on each 16-bit half, so every stage divides by two.
  function automatic cplx_t cplxHalve(input cplx_t x);
    cplx_t y;
    y.re = $signed(x.re) >>> 1;
    y.im = $signed(x.im) >>> 1;
    return y;
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational operand/twiddle address generator for stage s, butterfly k of an
// in-place radix-2 DIT FFT over bit-reversed input.
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int LOG2N = 4,
  parameter int AW    = LOG2N
) (
  input  logic [AW-1:0]    i_stage,
  input  logic [LOG2N-2:0] i_k,
  output logic [AW-1:0]    o_addrA,
  output logic [AW-1:0]    o_addrB,
  output logic [LOG2N-2:0] o_twAddr
);

  localparam int KW = LOG2N - 1;

  logic [KW-1:0] w_mask;
  logic [KW-1:0] w_pos;
  logic [KW-1:0] w_group;
  logic [AW-1:0] w_stagePlus1;
  logic [AW-1:0] w_twShift;
  logic [AW-1:0] w_addrA;

  // In the last stage the all-ones shift leaves zero, so the mask covers all of k.
  always_comb begin
    w_mask       = ~({KW{1'b1}} << i_stage);
    w_pos        = i_k & w_mask;
    w_group      = i_k >> i_stage;
    w_stagePlus1 = i_stage + AW'(1);
    w_twShift    = AW'(LOG2N - 1) - i_stage;
    w_addrA      = (AW'(w_group) << w_stagePlus1) | AW'(w_pos);
    o_addrA      = w_addrA;
    o_addrB      = w_addrA + (AW'(1) << i_stage);
    o_twAddr     = w_pos << w_twShift;
  end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Sequences all LOG2N radix-2 stages over memory: issue, butterfly, registered writeback.
// Define FFT_SCALE_EN to halve each result half per stage before writeback.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int N     = 16,
  parameter int LOG2N = 4,
  parameter int AW    = LOG2N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [AW-1:0]    rd_addr_a,
  output logic [AW-1:0]    rd_addr_b,
  output logic [LOG2N-2:0] tw_addr,
  input  logic [31:0]      rd_data_a,
  input  logic [31:0]      rd_data_b,
  input  logic [31:0]      tw_data,
  output logic [31:0]      bf_a,
  output logic [31:0]      bf_b,
  output logic [31:0]      bf_w,
  input  logic [31:0]      bf_out1,
  input  logic [31:0]      bf_out2,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr_a,
  output logic [AW-1:0]    wr_addr_b,
  output logic [31:0]      wr_data_a,
  output logic [31:0]      wr_data_b
);

  localparam int KW = LOG2N - 1;
  localparam logic [KW-1:0] K_LAST     = KW'(N / 2 - 1);
  localparam logic [AW-1:0] STAGE_LAST = AW'(LOG2N - 1);

  fft_state_t    r_state;
  fft_state_t    w_stateNext;
  logic [AW-1:0] r_stage;
  logic [AW-1:0] w_stageNext;
  logic [KW-1:0] r_k;
  logic [KW-1:0] w_kNext;
  logic          r_drain;
  logic          w_drainNext;
  logic          w_rdEn;
  logic          w_busy;
  logic          w_done;

  logic [AW-1:0] w_genA;
  logic [AW-1:0] w_genB;
  logic [KW-1:0] w_genTw;

  logic          r_rdValid;
  logic [AW-1:0] r_rdAddrA;
  logic [AW-1:0] r_rdAddrB;
  logic          r_wrEn;
  logic [AW-1:0] r_wrAddrA;
  logic [AW-1:0] r_wrAddrB;
  cplx_t         r_wrDataA;
  cplx_t         r_wrDataB;
  cplx_t         w_out1;
  cplx_t         w_out2;

  fft_addr_gen #(
    .LOG2N(LOG2N),
    .AW   (AW)
  ) u_addrGen (
    .i_stage (r_stage),
    .i_k     (r_k),
    .o_addrA (w_genA),
    .o_addrB (w_genB),
    .o_twAddr(w_genTw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_stage <= '0;
      r_k     <= '0;
      r_drain <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_stage <= w_stageNext;
      r_k     <= w_kNext;
      r_drain <= w_drainNext;
    end
  end

  // The two DRAIN cycles let the final write of a stage land before the next stage reads.
  always_comb begin
    w_stateNext = r_state;
    w_stageNext = r_stage;
    w_kNext     = r_k;
    w_drainNext = r_drain;
    w_rdEn      = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_stateNext = ST_RUN;
          w_stageNext = '0;
          w_kNext     = '0;
        end
      end
      ST_RUN: begin
        w_rdEn = 1'b1;
        w_busy = 1'b1;
        if (r_k == K_LAST) begin
          w_stateNext = ST_DRAIN;
          w_drainNext = 1'b0;
        end else begin
          w_kNext = r_k + KW'(1);
        end
      end
      ST_DRAIN: begin
        w_busy = 1'b1;
        if (!r_drain) begin
          w_drainNext = 1'b1;
        end else if (r_stage == STAGE_LAST) begin
          w_stateNext = ST_FINISH;
        end else begin
          w_stateNext = ST_RUN;
          w_stageNext = r_stage + AW'(1);
          w_kNext     = '0;
        end
      end
      ST_FINISH: begin
        w_done      = 1'b1;
        w_stateNext = ST_IDLE;
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

`ifdef FFT_SCALE_EN
  assign w_out1 = cplxHalve(bf_out1);
  assign w_out2 = cplxHalve(bf_out2);
`else
  assign w_out1 = bf_out1;
  assign w_out2 = bf_out2;
`endif

  // Write addresses trail the read addresses by two cycles; data is captured while the butterfly settles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdValid <= 1'b0;
      r_rdAddrA <= '0;
      r_rdAddrB <= '0;
      r_wrEn    <= 1'b0;
      r_wrAddrA <= '0;
      r_wrAddrB <= '0;
      r_wrDataA <= '0;
      r_wrDataB <= '0;
    end else begin
      r_rdValid <= w_rdEn;
      r_rdAddrA <= rd_addr_a;
      r_rdAddrB <= rd_addr_b;
      r_wrEn    <= r_rdValid;
      if (r_rdValid) begin
        r_wrAddrA <= r_rdAddrA;
        r_wrAddrB <= r_rdAddrB;
        r_wrDataA <= w_out1;
        r_wrDataB <= w_out2;
      end
    end
  end

  assign busy      = w_busy;
  assign done      = w_done;
  assign rd_en     = w_rdEn;
  assign rd_addr_a = w_rdEn ? w_genA  : '0;
  assign rd_addr_b = w_rdEn ? w_genB  : '0;
  assign tw_addr   = w_rdEn ? w_genTw : '0;

  assign bf_a = rd_data_a;
  assign bf_b = rd_data_b;
  assign bf_w = tw_data;

  assign wr_en     = r_wrEn;
  assign wr_addr_a = r_wrAddrA;
  assign wr_addr_b = r_wrAddrB;
  assign wr_data_a = r_wrDataA;
  assign wr_data_b = r_wrDataB;

endmodule

// File: doc/fft_stage_sequencer.md
# fft_stage_sequencer

In-place radix-2 decimation-in-time FFT sequencer. It drives the combinational butterfly: it reads each operand pair (a, b) from sample memory and the twiddle w from ROM, presents them to the butterfly, and writes the butterfly's out1/out2 back to the same addresses. It runs all LOG2N stages over an N-point frame that is already stored in bit-reversed order. It sits between the sample-memory/twiddle-ROM and the butterfly datapath.

## Interface
- N, 16: FFT points, power of two, 4..1024
- LOG2N, 4: log2(N)
- AW, LOG2N: sample address width
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin transform; sampled only in IDLE
- busy  out  1  high while transform in progress
- done  out  1  one-cycle pulse after final write
- rd_en  out  1  read strobe to sample memory and twiddle ROM
- rd_addr_a, rd_addr_b  out  AW  sample read addresses
- tw_addr  out  LOG2N-1  twiddle ROM index
- rd_data_a, rd_data_b  in  32  sample data, valid 1 cycle after rd_en
- tw_data  in  32  twiddle, valid 1 cycle after rd_en
- bf_a, bf_b, bf_w  out  32  butterfly operands (combinational pass-through of rd_data_a/rd_data_b/tw_data)
- bf_out1, bf_out2  in  32  butterfly results
- wr_en  out  1  write strobe
- wr_addr_a, wr_addr_b  out  AW  write addresses
- wr_data_a, wr_data_b  out  32  write data

All 32-bit words are packed complex values: real in [31:16], imag in [15:0], each 16-bit two's complement.

## Operation
- FSM states: IDLE, RUN, DRAIN, FINISH.
  - IDLE: start=1 goes to RUN, with stage s=0 and butterfly k=0.
  - RUN: one butterfly issued per cycle (rd_en=1). After k=N/2-1, go to DRAIN.
  - DRAIN: 2 cycles, no issue. Then either s++, k=0, back to RUN, or go to FINISH if s=LOG2N-1.
  - FINISH: 1 cycle, done=1, then IDLE.
- Address generation for stage s, butterfly k:
  - span = 1<<s, pos = k & (span-1), group = k>>s.
  - rd_addr_a = (group<<(s+1)) | pos
  - rd_addr_b = rd_addr_a + span
  - tw_addr = pos<<(LOG2N-1-s)
- Pipeline: issue (cycle c) -> data/butterfly (c+1) -> registered write (c+2).
  - Write addresses are delayed copies of the read addresses.
  - wr_data_a/wr_data_b come from bf_out1/bf_out2, registered at the end of cycle c+1.
- Hazards:
  - Pairs within a stage are disjoint, so there is no intra-stage hazard.
  - DRAIN guarantees the last write of stage s commits before the first read of stage s+1.
- start while busy: ignored.
- Reset: async assertion at any time, including mid-transform. All state and outputs go to 0 and the FSM to IDLE. Memory contents are left partially transformed; no write is issued after reset asserts.
- Butterfly arithmetic is external; this block does not alter data except under FFT_SCALE_EN.

## Timing
- Reset values: busy=0, done=0, rd_en=0, wr_en=0, all addresses 0, all wr_data 0.
- Let start be sampled high at edge T.
  - busy=1 and first rd_en=1 in cycle T+1.
  - Each stage occupies N/2+2 cycles.
  - Last wr_en occurs in cycle T+LOG2N*(N/2+2).
  - done=1 and busy=0 in cycle T+LOG2N*(N/2+2)+1. For N=16 that is T+41.
- wr_en is high exactly 2 cycles after each rd_en; N/2·LOG2N writes per transform.
- A new start is accepted in the cycle after done.

## Configuration
- FFT_SCALE_EN defined: each 16-bit half of wr_data_a/wr_data_b is arithmetic-shifted right by 1 before writeback (divide by 2 per stage, total 1/N). This prevents overflow.
- FFT_SCALE_EN undefined: bf_out1/bf_out2 are written unmodified.
- Timing is identical in both builds.

## Structure
- Package fft_pkg holds:
  - typedef cplx_t: packed struct, re[15:0], im[15:0]
  - FSM state enum
  - function for the arithmetic right shift of a cplx_t
- Sub-module fft_addr_gen: combinational (s, k) -> rd_addr_a, rd_addr_b, tw_addr.
- The sequencer contains the FSM, counters, and write pipeline registers.
- The bench instantiates the butterfly, a 2R/2W sample memory, and the twiddle ROM.

## Test plan
- N=16 address sequence:
  - Stage 0, k=0: addresses (0,1), tw 0.
  - Stage 1, k=1: addresses (1,3), tw 4.
  - Stage 3, k=7: addresses (7,15), tw 7.
  - 32 writes total.
- Impulse: mem[0]=0x0010_0000, others 0, start.
  - Without FFT_SCALE_EN: all 16 words = 0x0010_0000.
  - With FFT_SCALE_EN: all 16 words = 0x0001_0000.
- Latency: start at T gives first rd_en at T+1, last wr_en at T+40, and a one-cycle done plus busy fall at T+41.
- start pulsed at T+5 while busy: no restart; done still at T+41 and address sequence unchanged.
- rst_n low at T+12: outputs 0 immediately, FSM to IDLE, no further wr_en. A subsequent start runs a full 41-cycle transform.
- Back-to-back: start in the cycle after done is accepted. The second run repeats the identical address sequence.
